// File: rtl/cla_lookahead4.sv
// 4-bit carry-lookahead generator: intra-group carries C1..C4 plus group G/P,
// optionally registered, with a one-cycle out_valid that tracks in_valid.
module cla_lookahead4 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic g0,
  input  logic p0,
  input  logic g1,
  input  logic p1,
  input  logic g2,
  input  logic p2,
  input  logic g3,
  input  logic p3,
  input  logic cin,
  output logic C1,
  output logic C2,
  output logic C3,
  output logic C4,
  output logic G,
  output logic P,
  output logic out_valid
);

  // Handshake: valid-only, no backpressure. in_valid qualifies g/p/cin in the
  // cycle it is high; out_valid marks the C/G/P set from that input one edge later.

  logic c1_n, c2_n, c3_n, c4_n, g_n, p_n;

  // Flat sum-of-products so no carry ripples through an earlier carry.
  always_comb begin
    c1_n = g0 | (p0 & cin);
    c2_n = g1 | (p1 & g0) | (p1 & p0 & cin);
    c3_n = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & cin);
    c4_n = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0)
         | (p3 & p2 & p1 & p0 & cin);
    g_n  = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);
    p_n  = p3 & p2 & p1 & p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

  generate
    if (REG_OUT) begin : g_reg
      // Capture is unconditional; in_valid only steers out_valid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          C1 <= 1'b0;
          C2 <= 1'b0;
          C3 <= 1'b0;
          C4 <= 1'b0;
          G  <= 1'b0;
          P  <= 1'b0;
        end else begin
          C1 <= c1_n;
          C2 <= c2_n;
          C3 <= c3_n;
          C4 <= c4_n;
          G  <= g_n;
          P  <= p_n;
        end
      end
    end else begin : g_comb
      always_comb begin
        C1 = c1_n;
        C2 = c2_n;
        C3 = c3_n;
        C4 = c4_n;
        G  = g_n;
        P  = p_n;
      end
    end
  endgenerate

endmodule

// File: tb/tb_cla_lookahead4.sv
// Self-checking bench for cla_lookahead4 (REG_OUT=1): directed steps, exhaustive
// sweep, async reset and in_valid toggling, checked through an expected queue.
module tb_cla_lookahead4;

  logic clk, rst, in_valid;
  logic g0, p0, g1, p1, g2, p2, g3, p3, cin;
  logic C1, C2, C3, C4, G, P, out_valid;

  int total = 0;
  int bad   = 0;

  // entry: {valid, cin, c1, c2, c3, c4, G, P}
  logic [7:0] exp_q[$];

  cla_lookahead4 #(.REG_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .g0(g0), .p0(p0), .g1(g1), .p1(p1), .g2(g2), .p2(p2), .g3(g3), .p3(p3),
    .cin(cin),
    .C1(C1), .C2(C2), .C3(C3), .C4(C4), .G(G), .P(P), .out_valid(out_valid)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Ripple-form reference model: independent of the flat equations in the RTL.
  function automatic logic [7:0] model(input logic [8:0] v, input logic vld);
    logic [3:0] g, p;
    logic [4:0] c;
    logic gg;
    g = v[8:5];
    p = v[4:1];
    c[0] = v[0];
    gg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      gg     = g[i] | (p[i] & gg);
    end
    return {vld, v[0], c[1], c[2], c[3], c[4], gg, &p};
  endfunction

  function automatic logic [6:0] dut_outs();
    return {out_valid, C1, C2, C3, C4, G, P};
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, expv);
    end
  endtask

  // driver: v = {g3..g0, p3..p0, cin}
  task automatic drive(input logic [8:0] v, input logic vld);
    {g3, g2, g1, g0} = v[8:5];
    {p3, p2, p1, p0} = v[4:1];
    cin      = v[0];
    in_valid = vld;
    exp_q.push_back(model(v, vld));
  endtask

  // scoreboard: one edge later, pop and compare outputs plus the C4 invariant
  task automatic step(input string tag, input logic [8:0] v, input logic vld);
    logic [7:0] e;
    drive(v, vld);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s obs=empty_queue exp=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, dut_outs(), {e[7], e[5:0]});
      check({tag, "_inv"}, {6'd0, C4}, {6'd0, G | (P & e[6])});
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(9'b1111_1111_1, 1'b1);
    void'(exp_q.pop_front());
    #1;
    check("reset_t0", dut_outs(), 7'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", dut_outs(), 7'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    step("tp1_a", {4'b1101, 4'b1010, 1'b0}, 1'b1);
    step("tp1_hold", {4'b1101, 4'b1010, 1'b0}, 1'b1);
    step("allp_cin1", {4'b0000, 4'b1111, 1'b1}, 1'b1);
    step("allp_cin0", {4'b0000, 4'b1111, 1'b0}, 1'b1);
    step("zero_cin1", {4'b0000, 4'b0000, 1'b1}, 1'b1);
    step("g0_p321", {4'b0001, 4'b1110, 1'b0}, 1'b1);
    step("gp_both", {4'b1111, 4'b1111, 1'b0}, 1'b1);

    for (int i = 0; i < 512; i++) step("sweep", i[8:0], 1'b1);

    for (int i = 0; i < 20; i++) step("rand", 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));

    // async reset between edges with nonzero outputs
    step("pre_rst", {4'b1111, 4'b0000, 1'b1}, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", dut_outs(), 7'd0);
    @(posedge clk);
    #1;
    check("rst_hold", dut_outs(), 7'd0);
    @(negedge clk);
    rst = 1'b0;
    drive({4'b0000, 4'b1111, 1'b1}, 1'b1);
    @(posedge clk);
    #1;
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("post_rst", dut_outs(), {e[7], e[5:0]});
      check("post_rst_const", dut_outs(), 7'b1_1111_01);
    end

    step("vld_1", {4'b0110, 4'b1001, 1'b1}, 1'b1);
    step("vld_0", {4'b0110, 4'b1001, 1'b1}, 1'b0);
    step("vld_1b", {4'b0110, 4'b1001, 1'b1}, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_lookahead4.md
Name: cla_lookahead4

Overview:
- 4-bit carry-lookahead generator. Takes per-bit generate/propagate signals plus a carry-in; produces the intra-group carries C1..C4 and the group generate/propagate pair G/P.
- Used as the carry network of a 4-bit CLA adder slice, or cascaded as a second-level lookahead unit (G/P feed the next level).
- Logic is computed combinationally. Outputs are registered on one clock with an asynchronous active-high reset.

Parameters:
- REG_OUT, 1: 1 = outputs registered (1-cycle latency); 0 = outputs driven directly by the combinational logic, and clk/rst affect only out_valid.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  qualifies g0..p3 and cin this cycle
- g0  input  1  bit-0 generate
- p0  input  1  bit-0 propagate
- g1  input  1  bit-1 generate
- p1  input  1  bit-1 propagate
- g2  input  1  bit-2 generate
- p2  input  1  bit-2 propagate
- g3  input  1  bit-3 generate
- p3  input  1  bit-3 propagate
- cin  input  1  carry into bit 0
- C1  output  1  carry into bit 1
- C2  output  1  carry into bit 2
- C3  output  1  carry into bit 3
- C4  output  1  carry out of the group
- G  output  1  group generate
- P  output  1  group propagate
- out_valid  output  1  C1..C4/G/P correspond to a valid input set

Behaviour:
- Lookahead equations, all pure AND/OR with no ripple through earlier carries:
  - C1 = g0 | p0·cin
  - C2 = g1 | p1·g0 | p1·p0·cin
  - C3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·cin
  - C4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·cin
  - G = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 (independent of cin)
  - P = p3·p2·p1·p0 (independent of cin and of every g)
- Invariant: C4 == G | (P & cin).
- g and p are not required to be mutually exclusive. g=p=1 on a bit is legal and is treated as generate (the OR terms make this consistent).
- REG_OUT=1:
  - On each rising clk edge, C1..C4, G and P capture the equations evaluated on the current inputs, regardless of in_valid.
  - out_valid <= in_valid.
  - Latency is exactly 1 cycle; throughput is one input set per cycle.
- REG_OUT=0:
  - C1..C4/G/P follow the inputs combinationally.
  - out_valid is still in_valid delayed by one register.
- Reset:
  - rst=1 asynchronously forces C1..C4, G, P and out_valid to 0 immediately, without waiting for a clk edge.
  - The register contents stay 0 while rst is held.
  - On the first rising edge after rst deasserts, normal capture resumes.
  - Reset asserted mid-stream discards the in-flight result; out_valid drops in the same cycle.
- Inputs changing between edges have no effect on registered outputs until the next edge.
- No X-propagation masking: unknown inputs may yield unknown outputs.

Test Plan:
- g3..g0=1101, p3..p0=1010, cin=0, in_valid=1 -> after 1 clk: C1=1, C2=1, C3=1, C4=1, G=1, P=0, out_valid=1. Hold the identical vector a second cycle -> outputs unchanged.
- All p=1, all g=0, cin=1 -> C1..C4=1111, G=0, P=1. Then cin=0 -> C1..C4=0000, G=0, P=1. This checks the full propagate chain and that C4 = G|(P&cin).
- All g=0, all p=0, cin=1 -> C1..C4=0000, G=0, P=0. Then g0=1 only, p1=p2=p3=1 -> C1..C4=1111, G=1, P=0.
- Exhaustive sweep of all 512 input combinations, one per cycle, with in_valid=1 -> every registered output matches the equations one cycle later. The C4==G|(P&cin) invariant holds on every cycle.
- Assert rst between clock edges while outputs are nonzero -> all outputs and out_valid go 0 immediately, with no clk edge required. Deassert rst, apply all p=1, cin=1 -> next edge gives C1..C4=1111, P=1.
- Toggle in_valid 1,0,1 with fixed inputs -> out_valid follows 1,0,1 one cycle later, and C/G/P stay at the computed values throughout.
